gray_count_tracker: RTL and testbench
=====================================

# gray_count_tracker

Receive-side companion to a Gray-coded counter source. Samples an N-bit Gray-coded count, decodes it to binary, verifies that each new sample is a legal single-step advance, and extends the count to N+EXT bits by tracking wrap-arounds. Sits at the consumer end of a Gray-coded pointer or count bus, for example FIFO pointer comparison or event counting.

## Interface
- N, 4: width of the Gray-coded input and decoded binary output (N ≥ 2).
- EXT, 8: number of extra wrap-tracking bits in the extended count (EXT ≥ 1).
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- din_valid  input  1  din is sampled this cycle.
- din  input  N  Gray-coded count.
- clr  input  1  synchronous clear: return to IDLE, clear error.
- bin_out  output  N  decoded binary value of the last accepted sample.
- ext_count  output  N+EXT  extended count; low N bits equal bin_out.
- locked  output  1  high in LOCKED state.
- step  output  1  one-cycle pulse: the last sample advanced the count by exactly +1.
- wrap  output  1  one-cycle pulse: that advance wrapped from 2^N−1 to 0.
- err  output  1  sticky: an illegal transition was detected (high in ERROR state).

## Operation
- Decode rule: b[N−1] = g[N−1]; b[i] = b[i+1] ^ g[i] for i = N−2 down to 0.
- Internal registers: prev_gray[N], prev_bin[N], ext_count[N+EXT], state.
- States:
  - IDLE (reset state).
  - LOCKED.
  - ERROR.
- IDLE, din_valid=1:
  - Capture din into prev_gray.
  - bin_out/prev_bin ← decode(din).
  - ext_count ← {EXT'0, decode(din)}.
  - Go to LOCKED. No step or wrap pulse.
- LOCKED, din_valid=1: let d = popcount(din ^ prev_gray).
  - d = 0: hold all state. No pulse. Repeated samples are legal.
  - d = 1 and decode(din) == prev_bin+1 mod 2^N:
    - Accept the sample.
    - Update prev_gray, prev_bin and bin_out.
    - ext_count ← ext_count+1, modulo 2^(N+EXT).
    - step=1.
    - wrap=1 if prev_bin == 2^N−1.
  - Any other case (d ≥ 2, or d = 1 as a backward step):
    - Go to ERROR and set err.
    - bin_out, ext_count and prev_* hold their last legal values.
    - No step pulse.
- ERROR:
  - All samples are ignored and outputs hold.
  - Only clr (or reset) leaves this state.
- clr=1 in any state:
  - Next state is IDLE.
  - err ← 0. step and wrap ← 0.
  - bin_out, ext_count and prev_* ← 0.
  - A din_valid in the same cycle is discarded; clr wins.
- din_valid=0: hold everything. step and wrap deassert.
- ext_count wrap: the top of the range, 2^(N+EXT)−1, rolls to 0 silently. wrap reflects only the N-bit boundary.

## Timing
- All outputs are registered.
- Latency: a sample on cycle t is reflected in bin_out, ext_count, step, wrap, err and locked at cycle t+1.
- step and wrap are high for exactly one cycle per accepted advance. Back-to-back advances give continuous step pulses.
- Reset (resetn=0, asynchronous):
  - Outputs clear immediately: bin_out=0, ext_count=0, locked=0, step=0, wrap=0, err=0, state=IDLE.
  - Deassertion is synchronized externally. The first sample is accepted on the first rising edge with resetn=1.
- Reset in mid-stream discards the lock. The next valid sample re-locks, with ext_count upper bits = 0.
- The error transition is taken on the same edge that samples the bad value. err rises at t+1; locked falls at t+1.

## Test plan
- **Reset and lock:** apply reset, then din_valid=1 with din=4'b0000 → at t+1: locked=1, bin_out=0, ext_count=0, step=0, err=0.
- **Full wrap sweep (N=4):**
  - Stimulus: after locking at 0, feed Gray 1..15 (4'b0001 … 4'b1000), then 4'b0000, one per cycle.
  - Required response:
    - step is high on 16 consecutive cycles.
    - bin_out tracks 1..15, 0.
    - wrap pulses once, on the 15→0 step.
    - ext_count = 16 after the sweep.
- **Repeat and gap:** feed the same Gray value twice, then din_valid=0 for 3 cycles → no step, all outputs stable.
- **Illegal transition:**
  - Stimulus: locked at bin 3 (Gray 4'b0010), feed 4'b0111 (bin 5, d=2).
  - Required response:
    - err=1 and locked=0 at t+1.
    - bin_out stays 3.
    - Subsequent valid samples are ignored.
  - Repeat with 4'b0011 (bin 2, backward step) → same error response.
- **Clear vs. valid:** in ERROR, assert clr with din_valid=1 and din=4'b0001 → IDLE, err=0, outputs 0, sample discarded. The next valid sample re-locks.
- **Async reset mid-stream:** with ext_count=37, drop resetn between clock edges → all outputs 0 before the next edge. After release, the first sample re-locks with ext_count equal to its decoded value.

Source files
------------

// File: rtl/gray_count_tracker.sv
// gray_count_tracker
//   Receive-side tracker for a Gray-coded counter. It decodes each accepted
//   sample to binary and checks that every new sample is either a repeat or a
//   single +1 step. Wrap-arounds of the N-bit count are carried into an
//   N+EXT-bit extended count.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   din_valid  din is sampled this cycle
//   din[N]     Gray-coded count
//   clr        synchronous clear back to IDLE (beats din_valid)
//   bin_out    decoded binary value of the last accepted sample
//   ext_count  extended count; low N bits equal bin_out
//   locked     high while in LOCKED
//   step       one-cycle pulse on an accepted +1 advance
//   wrap       one-cycle pulse when that advance went 2^N-1 -> 0
//   err        sticky illegal-transition flag (ERROR state)
module gray_count_tracker #(
  parameter int N   = 4,
  parameter int EXT = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din_valid,
  input  logic [N-1:0]     din,
  input  logic             clr,
  output logic [N-1:0]     bin_out,
  output logic [N+EXT-1:0] ext_count,
  output logic             locked,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOCKED, ERROR} state_e;

  state_e           state_q;
  logic [N-1:0]     prev_gray_q, prev_bin_q;
  logic [N+EXT-1:0] ext_q;
  logic             locked_q, step_q, wrap_q, err_q;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [N-1:0] din_bin, diff, bin_inc;
  logic         same, one_bit, fwd;

  always_comb begin
    din_bin = gray2bin(din);
    diff    = din ^ prev_gray_q;
    bin_inc = prev_bin_q + N'(1);
    same    = (diff == '0);
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    one_bit = !same && ((diff & (diff - N'(1))) == '0);
    fwd     = one_bit && (din_bin == bin_inc);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      prev_gray_q <= '0;
      prev_bin_q  <= '0;
      ext_q       <= '0;
      locked_q    <= 1'b0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clr) begin
        state_q     <= IDLE;
        prev_gray_q <= '0;
        prev_bin_q  <= '0;
        ext_q       <= '0;
        locked_q    <= 1'b0;
        err_q       <= 1'b0;
      end else if (din_valid) begin
        case (state_q)
          IDLE: begin
            prev_gray_q <= din;
            prev_bin_q  <= din_bin;
            ext_q       <= {{EXT{1'b0}}, din_bin};
            state_q     <= LOCKED;
            locked_q    <= 1'b1;
          end
          LOCKED: begin
            if (same) begin
              // repeated sample: legal, nothing moves
            end else if (fwd) begin
              prev_gray_q <= din;
              prev_bin_q  <= din_bin;
              ext_q       <= ext_q + (N+EXT)'(1);
              step_q      <= 1'b1;
              wrap_q      <= (prev_bin_q == '1);
            end else begin
              // last legal value is kept; only clr or reset recovers
              state_q  <= ERROR;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
          end
          ERROR: begin
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bin_out   = prev_bin_q;
  assign ext_count = ext_q;
  assign locked    = locked_q;
  assign step      = step_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_gray_count_tracker.sv
module tb_gray_count_tracker;

  localparam int N   = 4;
  localparam int EXT = 8;

  logic             clk, resetn, din_valid, clr;
  logic [N-1:0]     din;
  logic [N-1:0]     bin_out;
  logic [N+EXT-1:0] ext_count;
  logic             locked, step, wrap, err;

  gray_count_tracker #(.N(N), .EXT(EXT)) dut (
    .clk(clk), .resetn(resetn), .din_valid(din_valid), .din(din), .clr(clr),
    .bin_out(bin_out), .ext_count(ext_count), .locked(locked),
    .step(step), .wrap(wrap), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: a plain integer count plus a mode flag.
  int m_mode;   // 0 idle, 1 locked, 2 error
  int m_ext;
  bit m_step, m_wrap;

  function automatic logic [N-1:0] gray(input int b);
    int g;
    g = (b ^ (b >> 1)) & ((1 << N) - 1);
    return g[N-1:0];
  endfunction

  function automatic int ungray(input logic [N-1:0] g);
    for (int b = 0; b < (1 << N); b++)
      if (gray(b) == g) return b;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ext = 0; m_step = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit c, input bit v, input logic [N-1:0] d);
    int pb;
    m_step = 0; m_wrap = 0;
    if (c) begin
      m_mode = 0; m_ext = 0;
    end else if (v) begin
      pb = m_ext % (1 << N);
      if (m_mode == 0) begin
        m_ext = ungray(d); m_mode = 1;
      end else if (m_mode == 1) begin
        if (d == gray(pb)) begin
        end else if (d == gray((pb + 1) % (1 << N))) begin
          m_step = 1;
          m_wrap = (pb == (1 << N) - 1);
          m_ext  = (m_ext + 1) % (1 << (N + EXT));
        end else begin
          m_mode = 2;
        end
      end
    end
  endtask

  task automatic check(input string name, input int ebin, input int eext,
                       input bit elk, input bit est, input bit ewr, input bit eer);
    n_vec++;
    if (bin_out !== ebin[N-1:0] || ext_count !== eext[N+EXT-1:0] || locked !== elk ||
        step !== est || wrap !== ewr || err !== eer) begin
      n_fail++;
      $display("FAIL %s: got bin=%0d ext=%0d lk=%0b st=%0b wr=%0b er=%0b, want bin=%0d ext=%0d lk=%0b st=%0b wr=%0b er=%0b",
               name, bin_out, ext_count, locked, step, wrap, err,
               ebin, eext, elk, est, ewr, eer);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_ext % (1 << N), m_ext, m_mode == 1, m_step, m_wrap, m_mode == 2);
  endtask

  // Called at a falling edge: drive, clock, return at the next falling edge.
  task automatic drive(input bit c, input bit v, input logic [N-1:0] d);
    clr = c; din_valid = v; din = d;
    @(posedge clk);
    model_step(c, v, d);
    @(negedge clk);
  endtask

  typedef struct {
    bit c; bit v; logic [N-1:0] d;
    int bin; int ext; bit lk; bit st; bit wr; bit er;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0, 1, 4'b0000, 0, 0, 1, 0, 0, 0};  // lock at 0
    tbl[1]  = '{0, 1, 4'b0001, 1, 1, 1, 1, 0, 0};
    tbl[2]  = '{0, 1, 4'b0011, 2, 2, 1, 1, 0, 0};
    tbl[3]  = '{0, 1, 4'b0011, 2, 2, 1, 0, 0, 0};  // repeat
    tbl[4]  = '{0, 0, 4'b1111, 2, 2, 1, 0, 0, 0};  // gap
    tbl[5]  = '{0, 1, 4'b0010, 3, 3, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, 4'b0111, 3, 3, 0, 0, 0, 1};  // d=2 -> error
    tbl[7]  = '{0, 1, 4'b0110, 3, 3, 0, 0, 0, 1};  // ignored in error
    tbl[8]  = '{1, 1, 4'b0001, 0, 0, 0, 0, 0, 0};  // clr beats valid
    tbl[9]  = '{0, 1, 4'b0010, 3, 3, 1, 0, 0, 0};  // relock at 3
    tbl[10] = '{0, 1, 4'b0011, 3, 3, 0, 0, 0, 1};  // backward step
    tbl[11] = '{1, 0, 4'b0000, 0, 0, 0, 0, 0, 0};

    model_reset();
    resetn = 1'b0; clr = 1'b0; din_valid = 1'b0; din = '0;
    #12;
    check("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].d);
      check($sformatf("tbl%0d", i), tbl[i].bin, tbl[i].ext, tbl[i].lk,
            tbl[i].st, tbl[i].wr, tbl[i].er);
    end

    // Full sweep through a wrap
    drive(0, 1, gray(0));
    check("sweep_lock", 0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, gray(k % 16));
      check($sformatf("sweep%0d", k), k % 16, k, 1, 1, (k == 16), 0);
    end
    drive(0, 0, '0);
    check("sweep_end", 0, 16, 1, 0, 0, 0);

    // Advance to ext_count = 37, then async reset between edges
    for (int k = 17; k <= 37; k++) drive(0, 1, gray(k % 16));
    check_model("to37");
    check("at37", 5, 37, 1, 1, 0, 0);
    #2 resetn = 1'b0;
    #1 check("async_rst", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 1, gray(6));
    check("relock", 6, 6, 1, 0, 0, 0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      int r, pb;
      logic [N-1:0] d;
      bit c, v;
      r  = $urandom_range(0, 99);
      pb = m_ext % (1 << N);
      c  = (r < 4);
      v  = (r >= 12);
      r  = $urandom_range(0, 99);
      if (r < 60)      d = gray((pb + 1) % (1 << N));
      else if (r < 80) d = gray(pb);
      else             d = N'($urandom_range(0, (1 << N) - 1));
      drive(c, v, d);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
